if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/riscv_pkg.sv | 18 +
 rtl/if_fetch_unit_if.sv | 34 +++
 rtl/fetch_buf.sv | 52 +++++
 rtl/if_fetch_unit.sv | 91 +++++++++
 tb/tb_if_fetch_unit.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding and the NOP
// instruction that fills an empty fetch buffer.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    FULL = 3'd3,
    DROP = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Bus bundle between the fetch unit, the PC register, instruction memory and
// decode. The fetch unit takes the master modport.
interface if_fetch_unit_if;
  import riscv_pkg::*;

  // Handshakes: a memory request transfers on a cycle with imem_req && imem_gnt,
  // and its data returns on a later cycle with imem_rvalid (at most one in
  // flight). An instruction transfers to decode on a cycle with
  // instr_valid && instr_ready; instr/instr_pc stay stable while valid and not
  // ready. stall low lets the PC register load its next value at the edge.
  logic [XLEN-1:0] pc;
  logic            stall;
  logic            flush;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_valid;
  logic            instr_ready;

  modport master (
    input  pc, flush, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    output stall, imem_req, imem_addr, instr, instr_pc, instr_valid
  );

  modport slave (
    output pc, flush, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
    input  stall, imem_req, imem_addr, instr, instr_pc, instr_valid
  );

endinterface

// File: rtl/fetch_buf.sv
// One-entry buffer holding the instruction handed to decode. Clear wins over
// load; with neither asserted the entry holds.
module fetch_buf
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            valid_o
);

  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;

  // Clearing restores the NOP but keeps the last address for debug visibility.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (clear_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load_i) begin
      instr_d = instr_i;
      pc_d    = pc_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: issues one memory read per instruction, buffers the
// result for decode and holds the PC until decode consumes it.
module if_fetch_unit
  import riscv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  if_fetch_unit_if.master      bus,
  output fetch_state_t         state_o
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic            buf_load;
  logic            buf_clear;
  logic            imem_req;
  logic [XLEN-1:0] buf_instr;
  logic [XLEN-1:0] buf_pc;
  logic            buf_valid;

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    imem_req   = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req = 1'b1;
        // A grant coinciding with a redirect still owes us a response to drain.
        if (bus.flush) begin
          state_d = bus.imem_gnt ? DROP : REQ;
        end else if (bus.imem_gnt) begin
          req_addr_d = bus.pc;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (bus.flush) begin
          state_d = bus.imem_rvalid ? REQ : DROP;
        end else if (bus.imem_rvalid) begin
          buf_load = 1'b1;
          state_d  = FULL;
        end
      end
      FULL: begin
        if (bus.flush || bus.instr_ready) begin
          buf_clear = 1'b1;
          state_d   = REQ;
        end
      end
      DROP: begin
        if (bus.imem_rvalid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
    end
  end

  fetch_buf u_fetch_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .instr_i (bus.imem_rdata),
    .pc_i    (req_addr_q),
    .instr_o (buf_instr),
    .pc_o    (buf_pc),
    .valid_o (buf_valid)
  );

  // The PC advances once per consumed instruction, or jumps on a redirect.
  assign bus.stall       = ~((buf_valid & bus.instr_ready) | bus.flush);
  assign bus.imem_req    = imem_req;
  assign bus.imem_addr   = bus.pc;
  assign bus.instr       = buf_instr;
  assign bus.instr_pc    = buf_pc;
  assign bus.instr_valid = buf_valid;
  assign state_o         = state_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a stimulus/expectation table walked one
// cycle per entry, plus hand-built redirect and reset sequences.
module tb_if_fetch_unit;
  import riscv_pkg::*;

  typedef struct {
    logic            rst, flush, gnt, rv;
    logic [31:0]     rdata;
    logic            rdy, pcs;
    logic [31:0]     pcv, tgt;
    fetch_state_t    st;
    logic            req;
    logic [31:0]     addr;
    logic            stall, iv;
    logic [31:0]     instr, ipc;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         flush, gnt, rv, rdy, pcs;
  logic [31:0]  rdata, pcv, tgt;
  logic [31:0]  pc_q, pc;
  fetch_state_t state;
  int           n_vec = 0;
  int           n_err = 0;
  vec_t         vecs[$];

  if_fetch_unit_if bus ();

  if_fetch_unit dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  // Environment PC register: redirect target on flush, +4 when not stalled.
  assign pc = pcs ? pcv : pc_q;
  always @(posedge clk) begin
    if (flush)           pc_q <= tgt;
    else if (!bus.stall) pc_q <= pc + 32'd4;
    else                 pc_q <= pc;
  end

  assign bus.pc          = pc;
  assign bus.flush       = flush;
  assign bus.imem_gnt    = gnt;
  assign bus.imem_rvalid = rv;
  assign bus.imem_rdata  = rdata;
  assign bus.instr_ready = rdy;

  function automatic vec_t mk(
    input logic r, input logic f, input logic g, input logic v,
    input logic [31:0] d, input logic rd, input logic ps,
    input logic [31:0] pv, input logic [31:0] t,
    input fetch_state_t s, input logic q, input logic [31:0] a,
    input logic sl, input logic ivl, input logic [31:0] ins,
    input logic [31:0] ip);
    vec_t x;
    x.rst = r; x.flush = f; x.gnt = g; x.rv = v; x.rdata = d; x.rdy = rd;
    x.pcs = ps; x.pcv = pv; x.tgt = t; x.st = s; x.req = q; x.addr = a;
    x.stall = sl; x.iv = ivl; x.instr = ins; x.ipc = ip;
    return x;
  endfunction

  task automatic chk(input string tag, input int idx, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] %s: actual %h, required %h", tag, idx, what, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag, input int idx);
    rst = v.rst; flush = v.flush; gnt = v.gnt; rv = v.rv; rdata = v.rdata;
    rdy = v.rdy; pcs = v.pcs; pcv = v.pcv; tgt = v.tgt;
    #1;
    n_vec++;
    chk(tag, idx, "state",       32'(state),           32'(v.st));
    chk(tag, idx, "imem_req",    32'(bus.imem_req),    32'(v.req));
    if (v.req) chk(tag, idx, "imem_addr", bus.imem_addr, v.addr);
    chk(tag, idx, "stall",       32'(bus.stall),       32'(v.stall));
    chk(tag, idx, "instr_valid", 32'(bus.instr_valid), 32'(v.iv));
    chk(tag, idx, "instr",       bus.instr,            v.instr);
    chk(tag, idx, "instr_pc",    bus.instr_pc,         v.ipc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; gnt = 1'b0; rv = 1'b0; rdata = '0;
    rdy = 1'b0; pcs = 1'b1; pcv = '0; tgt = '0;
    @(posedge clk);
    #1;

    //                rst f g rv rdata         rdy pcs pcv        tgt           st    req addr       stl iv instr          ipc
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 1, 32'h0,   32'h0,   IDLE, 0, 32'h0,   1, 0, NOP_INSTR,    32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 32'h0,   32'h0,   IDLE, 0, 32'h0,   1, 0, NOP_INSTR,    32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 32'h0,   32'h0,   REQ,  1, 32'h0,   1, 0, NOP_INSTR,    32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 1, 32'h100, 32'h0,   REQ,  1, 32'h100, 1, 0, NOP_INSTR,    32'h0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h00500093, 1, 0, 32'h0,   32'h0,   WAIT, 0, 32'h0,   1, 0, NOP_INSTR,    32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,   32'h0,   FULL, 0, 32'h0,   0, 1, 32'h00500093, 32'h100));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        1, 0, 32'h0,   32'h0,   REQ,  1, 32'h104, 1, 0, NOP_INSTR,    32'h100));
    vecs.push_back(mk(0, 0, 0, 1, 32'h00A00113, 0, 0, 32'h0,   32'h0,   WAIT, 0, 32'h0,   1, 0, NOP_INSTR,    32'h100));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,   32'h0,   FULL, 0, 32'h0,   1, 1, 32'h00A00113, 32'h104));
    vecs.push_back(mk(0, 0, 0, 1, 32'hFFFFFFFF, 0, 0, 32'h0,   32'h0,   FULL, 0, 32'h0,   1, 1, 32'h00A00113, 32'h104));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,   32'h0,   FULL, 0, 32'h0,   1, 1, 32'h00A00113, 32'h104));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,   32'h0,   FULL, 0, 32'h0,   1, 1, 32'h00A00113, 32'h104));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,   32'h0,   FULL, 0, 32'h0,   0, 1, 32'h00A00113, 32'h104));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,   32'h0,   REQ,  1, 32'h108, 1, 0, NOP_INSTR,    32'h104));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,   32'h200, WAIT, 0, 32'h0,   0, 0, NOP_INSTR,    32'h104));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,   32'h0,   DROP, 0, 32'h0,   1, 0, NOP_INSTR,    32'h104));
    vecs.push_back(mk(0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 32'h0,   32'h0,   DROP, 0, 32'h0,   1, 0, NOP_INSTR,    32'h104));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,   32'h0,   REQ,  1, 32'h200, 1, 0, NOP_INSTR,    32'h104));
    vecs.push_back(mk(0, 0, 0, 1, 32'h00000293, 0, 0, 32'h0,   32'h0,   WAIT, 0, 32'h0,   1, 0, NOP_INSTR,    32'h104));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 0, 32'h0,   32'h300, FULL, 0, 32'h0,   0, 1, 32'h00000293, 32'h200));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,   32'h0,   REQ,  1, 32'h300, 1, 0, NOP_INSTR,    32'h200));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 32'h0,   32'h0,   WAIT, 0, 32'h0,   1, 0, NOP_INSTR,    32'h200));
    vecs.push_back(mk(0, 0, 0, 1, 32'hBAD00BAD, 0, 0, 32'h0,   32'h0,   IDLE, 0, 32'h0,   1, 0, NOP_INSTR,    32'h0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hBAD00BAD, 0, 0, 32'h0,   32'h0,   REQ,  1, 32'h300, 1, 0, NOP_INSTR,    32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,   32'h0,   REQ,  1, 32'h300, 1, 0, NOP_INSTR,    32'h0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h00100073, 0, 0, 32'h0,   32'h0,   WAIT, 0, 32'h0,   1, 0, NOP_INSTR,    32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,   32'h0,   FULL, 0, 32'h0,   0, 1, 32'h00100073, 32'h300));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,   32'h0,   REQ,  1, 32'h304, 1, 0, NOP_INSTR,    32'h300));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], "tbl", i);

    // Redirect coinciding with a grant must drain the response in DROP.
    apply(mk(0, 1, 1, 0, 32'h0,        0, 0, 32'h0, 32'h400, REQ,  1, 32'h304, 0, 0, NOP_INSTR, 32'h300), "seq", 0);
    apply(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0, 32'h0,   DROP, 0, 32'h0,   1, 0, NOP_INSTR, 32'h300), "seq", 1);
    apply(mk(0, 0, 0, 1, 32'h11111111, 0, 0, 32'h0, 32'h0,   DROP, 0, 32'h0,   1, 0, NOP_INSTR, 32'h300), "seq", 2);
    apply(mk(0, 0, 1, 0, 32'h0,        0, 0, 32'h0, 32'h0,   REQ,  1, 32'h400, 1, 0, NOP_INSTR, 32'h300), "seq", 3);
    // Redirect with data arriving the same cycle: data dropped, straight to REQ.
    apply(mk(0, 1, 0, 1, 32'h22222222, 0, 0, 32'h0, 32'h500, WAIT, 0, 32'h0,   0, 0, NOP_INSTR, 32'h300), "seq", 4);
    apply(mk(0, 1, 0, 0, 32'h0,        0, 0, 32'h0, 32'h600, REQ,  1, 32'h500, 0, 0, NOP_INSTR, 32'h300), "seq", 5);
    apply(mk(1, 0, 0, 0, 32'h0,        0, 0, 32'h0, 32'h0,   REQ,  1, 32'h600, 1, 0, NOP_INSTR, 32'h300), "seq", 6);
    // Redirect in IDLE releases the PC but does not disturb the FSM.
    apply(mk(0, 1, 0, 0, 32'h0,        0, 0, 32'h0, 32'h700, IDLE, 0, 32'h0,   0, 0, NOP_INSTR, 32'h0),   "seq", 7);
    apply(mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h0, 32'h0,   REQ,  1, 32'h700, 1, 0, NOP_INSTR, 32'h0),   "seq", 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
